apb_slave_mem: RTL and testbench

APB3 completer backed by a word-addressed register memory, with programmable wait states and error response. It drives `pready`, `prdata` and `pslverr` onto the same APB bus that the protocol assertion monitor observes. It is the DUT-side counterpart of that monitor and the reference slave for the APB3 VIP environment.

---
 rtl/apb_slave_pkg.sv | 24 ++
 rtl/apb_slave_regfile.sv | 31 +++
 rtl/apb_slave_mem.sv | 110 +++++++++++
 tb/tb_apb_slave_mem.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types, widths and helpers for the APB3 register-memory completer.
package apb_slave_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned WAIT_W     = 4;
    localparam int unsigned ERR_CNT_W  = 16;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word-addressed storage: synchronous clear, one write port, one combinational read port.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [APB_DATA_W-1:0] rdata_o
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer over a register memory with programmable wait states,
// address-error response and a saturating error counter.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned           DEPTH     = 256,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic [WAIT_W-1:0]     wait_cfg,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    apb_state_e              state_q;
    logic [WAIT_W-1:0]       wcnt_q;
    logic [APB_ADDR_W-1:0]   addr_q;
    logic                    write_q;
    logic [ERR_CNT_W-1:0]    err_cnt_q;
    logic [ERR_CNT_W-1:0]    err_cnt_d;

    apb_req_t                req;
    logic                    complete;
    logic                    addr_err;
    logic                    mem_we;
    logic [IDX_W-1:0]        idx;
    logic [APB_DATA_W-1:0]   mem_rdata;

    // Write data is taken live from the bus so it is sampled at the completing edge.
    assign req = '{addr: addr_q, write: write_q, wdata: pwdata};

    // BASE_ADDR is aligned to the window size, so the range check reduces to
    // comparing the bits above the word index.
    assign addr_err = (req.addr[1:0] != 2'b00) ||
                      (req.addr[APB_ADDR_W-1:IDX_W+2] != BASE_ADDR[APB_ADDR_W-1:IDX_W+2]);
    assign idx      = req.addr[IDX_W+1:2];

    assign complete = rst_n && (state_q == ACCESS) && psel && penable && (wcnt_q == '0);
    assign mem_we   = complete && req.write && !addr_err;

    assign pready   = complete;
    assign pslverr  = complete && addr_err;
    assign prdata   = (complete && !addr_err && !req.write) ? mem_rdata : '0;
    assign err_cnt  = err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (complete && addr_err) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wcnt_q  <= wait_cfg;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (penable) begin
                        if (wcnt_q != '0) begin
                            wcnt_q <= wcnt_q - 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_slave_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .widx_i  (idx),
        .wdata_i (req.wdata),
        .ridx_i  (idx),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem against an array-based memory/error model.
module tb_apb_slave_mem;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  wait_cfg = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] ref_mem [DEPTH];
    int unsigned ref_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_mem #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pwdata   (pwdata),
        .wait_cfg (wait_cfg),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .err_cnt  (err_cnt)
    );

    function automatic void ref_reset();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_err = 0;
    endfunction

    function automatic bit ref_is_err(input logic [31:0] a);
        longint unsigned la = 64'(a);
        return ((a % 4) != 0) || (la < 64'(BASE)) || (la >= 64'(BASE) + 64'(DEPTH) * 4);
    endfunction

    function automatic void ref_apply(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] exp_rd, output bit exp_err);
        int idx;
        exp_err = ref_is_err(addr);
        exp_rd  = '0;
        idx     = int'((addr - BASE) / 4);
        if (exp_err) begin
            if (ref_err < 65535) ref_err++;
        end else if (wr) begin
            ref_mem[idx] = wdata;
        end else begin
            exp_rd = ref_mem[idx];
        end
    endfunction

    // Bus driver: one full transfer; entered and left just after a rising edge.
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] ws, output logic [31:0] rdata, output bit err,
                           output int lat, output int done_cyc);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = ~wdata; wait_cfg = ws;
        @(negedge clk);
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL setup_pready addr=%h got=%b want=0", addr, pready);
        end
        @(posedge clk); #1;
        penable = 1'b1; pwdata = wdata; wait_cfg = 4'($urandom);
        lat = 1; rdata = '0; err = 1'b0; done_cyc = -1;
        forever begin
            @(negedge clk);
            if (pready === 1'b1) begin
                rdata = prdata; err = pslverr; done_cyc = cyc;
                break;
            end
            checks++;
            if (prdata !== '0 || pslverr !== 1'b0) begin
                errors++;
                $display("FAIL wait_outputs addr=%h got prdata=%h pslverr=%b want 0/0", addr, prdata, pslverr);
            end
            if (lat >= 40) begin
                errors++;
                $display("FAIL timeout addr=%h got no pready want pready within 40 cycles", addr);
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; paddr = $urandom; pwdata = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            psel = 1'($urandom); penable = 1'($urandom); paddr = $urandom & 32'h3FC;
            @(negedge clk);
            checks++;
            if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got pready=%b prdata=%h pslverr=%b want 0/0/0", pready, prdata, pslverr);
            end
        end
        checks++;
        if (err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_err_cnt got=%h want=0000", err_cnt);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        ref_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc;
        ref_apply(1'b0, 32'h0, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h0, '0, 4'd3, rd, er, lat, dc);
        checks++;
        if (lat != 4 || rd !== 32'h0 || rd !== exp_rd || er !== 1'b0) begin
            errors++;
            $display("FAIL wait3_read got lat=%0d prdata=%h err=%b want lat=4 prdata=0 err=0", lat, rd, er);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc;
        ref_apply(1'b1, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, rd, er, lat, dc);
        checks++;
        if (lat != 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL zw_write got lat=%0d err=%b want lat=1 err=0", lat, er);
        end
        ref_apply(1'b0, 32'h10, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h10, '0, 4'd0, rd, er, lat, dc);
        checks++;
        if (lat != 1 || er !== 1'b0 || rd !== 32'hDEADBEEF || rd !== exp_rd) begin
            errors++;
            $display("FAIL zw_read got lat=%0d prdata=%h err=%b want lat=1 prdata=deadbeef err=0", lat, rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc;
        ref_apply(1'b1, 32'h402, 32'hCAFEF00D, exp_rd, exp_er);
        do_xfer(1'b1, 32'h402, 32'hCAFEF00D, 4'd1, rd, er, lat, dc);
        checks++;
        if (lat != 2 || er !== 1'b1 || er !== exp_er) begin
            errors++;
            $display("FAIL err_write_unaligned got lat=%0d err=%b want lat=2 err=1", lat, er);
        end
        ref_apply(1'b0, 32'h400, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h400, '0, 4'd0, rd, er, lat, dc);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_read_range got lat=%0d prdata=%h err=%b want lat=1 prdata=0 err=1", lat, rd, er);
        end
        checks++;
        if (err_cnt !== 16'd2 || err_cnt !== 16'(ref_err)) begin
            errors++;
            $display("FAIL err_cnt_two got=%0d want=2", err_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h0 : 32'h400 & 32'h3FC;
            ref_apply(1'b0, a, '0, exp_rd, exp_er);
            do_xfer(1'b0, a, '0, 4'd0, rd, er, lat, dc);
            checks++;
            if (rd !== exp_rd || er !== 1'b0) begin
                errors++;
                $display("FAIL err_mem_untouched addr=%h got=%h want=%h", a, rd, exp_rd);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc; int seen;
        logic [15:0] cnt_before;
        cnt_before = err_cnt;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h1234_5678; wait_cfg = 4'd2;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pready !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0 || err_cnt !== cnt_before) begin
            errors++;
            $display("FAIL abort_no_pready got pulses=%0d err_cnt=%0d want pulses=0 err_cnt=%0d", seen, err_cnt, cnt_before);
        end
        ref_apply(1'b0, 32'h8, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h8, '0, 4'd0, rd, er, lat, dc);
        checks++;
        if (rd !== 32'h0 || rd !== exp_rd || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write got prdata=%h want=00000000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc, t0;
        logic [31:0] data [3];
        for (int i = 0; i < 3; i++) data[i] = $urandom;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            ref_apply(1'b1, 32'(i * 4), data[i], exp_rd, exp_er);
            do_xfer(1'b1, 32'(i * 4), data[i], 4'd0, rd, er, lat, dc);
            checks++;
            if (dc - t0 != 2 * i + 1 || er !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pulse%0d got cycle=%0d err=%b want cycle=%0d err=0", i, dc - t0, er, 2 * i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ref_apply(1'b0, 32'(i * 4), '0, exp_rd, exp_er);
            do_xfer(1'b0, 32'(i * 4), '0, 4'd0, rd, er, lat, dc);
            checks++;
            if (rd !== exp_rd || rd !== data[i]) begin
                errors++;
                $display("FAIL b2b_readback%0d got=%h want=%h", i, rd, data[i]);
            end
        end
    endtask

    task automatic test_penable_in_idle();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc; int seen;
        seen = 0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (pready !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL idle_penable got pulses=%0d want 0", seen);
        end
        ref_apply(1'b0, 32'h10, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h10, '0, 4'd0, rd, er, lat, dc);
        checks++;
        if (lat != 1 || rd !== exp_rd) begin
            errors++;
            $display("FAIL idle_penable_read got lat=%0d prdata=%h want lat=1 prdata=%h", lat, rd, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, a, wd, last_a; bit er, exp_er, wr, last_wr; int lat, dc; logic [3:0] ws;
        last_a = 32'h0; last_wr = 1'b0;
        for (int n = 0; n < 80; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15) * 4);
            else if (r == 7) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
            else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            else             a = $urandom;
            wr = 1'($urandom);
            if (last_wr && $urandom_range(0, 2) == 0) begin a = last_a; wr = 1'b0; end
            wd = $urandom;
            ws = 4'($urandom_range(0, 3));
            ref_apply(wr, a, wd, exp_rd, exp_er);
            do_xfer(wr, a, wd, ws, rd, er, lat, dc);
            checks++;
            if (lat != int'(ws) + 1 || er !== exp_er || (!wr && rd !== exp_rd) || err_cnt !== 16'(ref_err)) begin
                errors++;
                $display("FAIL rand%0d %s addr=%h got lat=%0d err=%b prdata=%h err_cnt=%0d want lat=%0d err=%b prdata=%h err_cnt=%0d",
                         n, wr ? "wr" : "rd", a, lat, er, rd, err_cnt, ws + 1, exp_er, exp_rd, ref_err);
            end
            last_a = a; last_wr = wr;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, exp_rd; bit er, exp_er; int lat, dc;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5A5A_A5A5; wait_cfg = 4'd5;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        checks++;
        if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midwait_reset got pready=%b prdata=%h pslverr=%b err_cnt=%0d want all 0",
                     pready, prdata, pslverr, err_cnt);
        end
        ref_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ref_apply(1'b0, 32'h20, '0, exp_rd, exp_er);
        do_xfer(1'b0, 32'h20, '0, 4'd0, rd, er, lat, dc);
        checks++;
        if (rd !== exp_rd || er !== 1'b0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midwait_word got prdata=%h err_cnt=%0d want prdata=%h err_cnt=0", rd, err_cnt, exp_rd);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_wait_states();
        test_zero_wait();
        test_errors();
        test_abort();
        test_back_to_back();
        test_penable_in_idle();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
